// File: rtl/gen_pixel_multi.sv
// Parametrised raster timing generator with selectable test patterns.
// Every output is registered from the same (cX,cY) pair, so all outputs stay mutually aligned.
module gen_pixel_multi #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int XFPORCH     = 16,
   parameter int XSYNC       = 96,
   parameter int XBLANK      = 160,
   parameter int YFPORCH     = 10,
   parameter int YSYNC       = 2,
   parameter int YBLANK      = 45,
   parameter int COOR_WIDTH  = 12,
   parameter bit HSYNC_POL   = 1'b1,
   parameter bit VSYNC_POL   = 1'b1,
   parameter int BANDS       = 4,
   parameter int CHECK_SHIFT = 5
) (
   input  logic                  pixclk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [23:0]           solid_rgb,
   output logic                  hSync,
   output logic                  vSync,
   output logic                  DrawArea,
   output logic [23:0]           pixel,
   output logic [COOR_WIDTH-1:0] xOut,
   output logic [COOR_WIDTH-1:0] yOut,
   output logic                  frame_start,
   output logic [15:0]           frame_cnt
);

   localparam int W2 = 2 * COOR_WIDTH;

   localparam logic [COOR_WIDTH-1:0] X_LAST = COOR_WIDTH'(WIDTH + XBLANK - 1);
   localparam logic [COOR_WIDTH-1:0] Y_LAST = COOR_WIDTH'(HEIGHT + YBLANK - 1);
   localparam logic [COOR_WIDTH-1:0] X_ACT  = COOR_WIDTH'(WIDTH);
   localparam logic [COOR_WIDTH-1:0] Y_ACT  = COOR_WIDTH'(HEIGHT);
   localparam logic [COOR_WIDTH-1:0] HS_BEG = COOR_WIDTH'(WIDTH + XFPORCH);
   localparam logic [COOR_WIDTH-1:0] HS_END = COOR_WIDTH'(WIDTH + XFPORCH + XSYNC);
   localparam logic [COOR_WIDTH-1:0] VS_BEG = COOR_WIDTH'(HEIGHT + YFPORCH);
   localparam logic [COOR_WIDTH-1:0] VS_END = COOR_WIDTH'(HEIGHT + YFPORCH + YSYNC);

   logic [COOR_WIDTH-1:0] r_cx;
   logic [COOR_WIDTH-1:0] r_cy;
   logic [1:0]            r_mode;
   logic [23:0]           r_solid;
   logic                  r_hsync;
   logic                  r_vsync;
   logic                  r_draw;
   logic [23:0]           r_pixel;
   logic [COOR_WIDTH-1:0] r_xout;
   logic [COOR_WIDTH-1:0] r_yout;
   logic                  r_fstart;
   logic [15:0]           r_fcnt;

   logic                  w_x_last;
   logic                  w_y_last;
   logic                  w_draw;
   logic                  w_hact;
   logic                  w_vact;
   logic [W2-1:0]         w_k;
   logic [7:0]            w_gray;
   logic [2:0]            w_bar;
   logic                  w_check;
   logic [23:0]           w_pattern;

   assign w_x_last = (r_cx == X_LAST);
   assign w_y_last = (r_cy == Y_LAST);
   assign w_draw   = (r_cx < X_ACT) && (r_cy < Y_ACT);
   assign w_hact   = (r_cx >= HS_BEG) && (r_cx < HS_END);
   assign w_vact   = (r_cy >= VS_BEG) && (r_cy < VS_END);

   // Band index and level are computed at double width so nothing is lost before the divide.
   assign w_k     = (W2'(r_cy) * W2'(BANDS)) / W2'(HEIGHT);
   assign w_gray  = 8'(W2'(255) - (w_k * W2'(255)) / W2'(BANDS - 1));
   assign w_bar   = 3'((W2'(r_cx) * W2'(8)) / W2'(WIDTH));
   assign w_check = r_cx[CHECK_SHIFT] ^ r_cy[CHECK_SHIFT];

   // NOTE: assign a default before the case so no path leaves w_pattern unassigned (no latch).
   always_comb begin
      w_pattern = r_solid;
      case (r_mode)
         2'd0:    w_pattern = {3{w_gray}};
         // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
         2'd1:    w_pattern = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
         2'd2:    w_pattern = w_check ? 24'h000000 : 24'hffffff;
         default: w_pattern = r_solid;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pixclk) begin
      if (rst) begin
         r_cx     <= '0;
         r_cy     <= '0;
         r_mode   <= 2'd0;
         r_solid  <= 24'h0;
         r_hsync  <= ~HSYNC_POL;
         r_vsync  <= ~VSYNC_POL;
         r_draw   <= 1'b0;
         r_pixel  <= 24'h0;
         r_xout   <= '0;
         r_yout   <= '0;
         r_fstart <= 1'b0;
         r_fcnt   <= 16'h0;
      end else if (en) begin
         r_cx <= w_x_last ? '0 : r_cx + COOR_WIDTH'(1);
         if (w_x_last) begin
            r_cy <= w_y_last ? '0 : r_cy + COOR_WIDTH'(1);
         end
         // Pattern selection only changes across the frame wrap.
         if (w_x_last && w_y_last) begin
            r_mode  <= mode;
            r_solid <= solid_rgb;
            r_fcnt  <= r_fcnt + 16'd1;
         end
         r_hsync  <= w_hact ? HSYNC_POL : ~HSYNC_POL;
         r_vsync  <= w_vact ? VSYNC_POL : ~VSYNC_POL;
         r_draw   <= w_draw;
         r_pixel  <= w_draw ? w_pattern : 24'h0;
         r_xout   <= r_cx;
         r_yout   <= r_cy;
         r_fstart <= (r_cx == '0) && (r_cy == '0);
      end
   end

   assign hSync       = r_hsync;
   assign vSync       = r_vsync;
   assign DrawArea    = r_draw;
   assign pixel       = r_pixel;
   assign xOut        = r_xout;
   assign yOut        = r_yout;
   assign frame_start = r_fstart;
   assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_gen_pixel_multi.sv
// Bench for gen_pixel_multi on a small raster: directed scenarios plus random en/mode/reset,
// all checked against a position-based reference model.
module tb_gen_pixel_multi;

   localparam int P_W     = 8;
   localparam int P_H     = 4;
   localparam int P_XF    = 1;
   localparam int P_XS    = 2;
   localparam int P_XB    = 4;
   localparam int P_YF    = 1;
   localparam int P_YS    = 1;
   localparam int P_YB    = 2;
   localparam int P_CW    = 12;
   localparam bit P_HPOL  = 1'b1;
   localparam bit P_VPOL  = 1'b0;
   localparam int P_BANDS = 4;
   localparam int P_CS    = 1;
   localparam int LINE    = P_W + P_XB;
   localparam int FRAME   = LINE * (P_H + P_YB);

   localparam logic [23:0] BAR_RGB [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                           24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
   localparam logic [23:0] GRAY [4]    = '{24'hffffff, 24'haaaaaa, 24'h555555, 24'h000000};
   localparam logic [23:0] CHK0 [8]    = '{24'hffffff, 24'hffffff, 24'h000000, 24'h000000,
                                           24'hffffff, 24'hffffff, 24'h000000, 24'h000000};
   localparam logic [23:0] CHK2 [8]    = '{24'h000000, 24'h000000, 24'hffffff, 24'hffffff,
                                           24'h000000, 24'h000000, 24'hffffff, 24'hffffff};

   logic            pixclk = 1'b0;
   logic            rst;
   logic            en;
   logic [1:0]      mode;
   logic [23:0]     solid_rgb;
   logic            hSync;
   logic            vSync;
   logic            DrawArea;
   logic [23:0]     pixel;
   logic [P_CW-1:0] xOut;
   logic [P_CW-1:0] yOut;
   logic            frame_start;
   logic [15:0]     frame_cnt;

   always #5 pixclk = ~pixclk;

   gen_pixel_multi #(
      .WIDTH(P_W), .HEIGHT(P_H), .XFPORCH(P_XF), .XSYNC(P_XS), .XBLANK(P_XB),
      .YFPORCH(P_YF), .YSYNC(P_YS), .YBLANK(P_YB), .COOR_WIDTH(P_CW),
      .HSYNC_POL(P_HPOL), .VSYNC_POL(P_VPOL), .BANDS(P_BANDS), .CHECK_SHIFT(P_CS)
   ) dut (
      .pixclk(pixclk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
      .hSync(hSync), .vSync(vSync), .DrawArea(DrawArea), .pixel(pixel),
      .xOut(xOut), .yOut(yOut), .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: linear raster position plus the latched pattern selection.
   int          m_pos;
   logic [1:0]  m_mode;
   logic [23:0] m_solid;
   logic [15:0] m_fcnt;
   logic        e_h, e_v, e_da, e_fs;
   logic [23:0] e_pix;
   int          e_x, e_y;

   function automatic logic [23:0] exp_pixel(input int x, input int y,
                                             input logic [1:0] md, input logic [23:0] sol);
      int k;
      int lvl;
      logic [7:0] l8;
      if (!(x < P_W && y < P_H)) return 24'h0;
      case (md)
         2'd0: begin
            k   = y * P_BANDS / P_H;
            lvl = 255 - (k * 255) / (P_BANDS - 1);
            l8  = 8'(lvl);
            return {l8, l8, l8};
         end
         2'd1:    return BAR_RGB[x * 8 / P_W];
         2'd2:    return ((((x >> P_CS) ^ (y >> P_CS)) & 1) != 0) ? 24'h000000 : 24'hffffff;
         default: return sol;
      endcase
   endfunction

   task automatic model_edge();
      int x;
      int y;
      if (rst) begin
         m_pos = 0; m_mode = 2'd0; m_solid = 24'h0; m_fcnt = 16'h0;
         e_h = !P_HPOL; e_v = !P_VPOL; e_da = 1'b0; e_fs = 1'b0;
         e_pix = 24'h0; e_x = 0; e_y = 0;
      end else if (en) begin
         x     = m_pos % LINE;
         y     = m_pos / LINE;
         e_x   = x;
         e_y   = y;
         e_da  = (x < P_W) && (y < P_H);
         e_h   = (x >= P_W + P_XF && x < P_W + P_XF + P_XS) ? P_HPOL : !P_HPOL;
         e_v   = (y >= P_H + P_YF && y < P_H + P_YF + P_YS) ? P_VPOL : !P_VPOL;
         e_fs  = (m_pos == 0);
         e_pix = exp_pixel(x, y, m_mode, m_solid);
         if (m_pos == FRAME - 1) begin
            m_mode  = mode;
            m_solid = solid_rgb;
            m_fcnt  = m_fcnt + 16'd1;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
   endtask

   task automatic check_all();
      check("xOut", 32'(xOut), 32'(e_x));
      check("yOut", 32'(yOut), 32'(e_y));
      check("hSync", 32'(hSync), 32'(e_h));
      check("vSync", 32'(vSync), 32'(e_v));
      check("DrawArea", 32'(DrawArea), 32'(e_da));
      check("pixel", 32'(pixel), 32'(e_pix));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
   endtask

   task automatic tick();
      @(posedge pixclk);
      model_edge();
      #1;
      check_all();
   endtask

   logic [23:0] pix [FRAME];
   int cnt_da, cnt_hs, cnt_vs_low, cnt_fs;

   task automatic run_range(input int lo, input int hi);
      for (int p = lo; p <= hi; p++) begin
         tick();
         pix[p] = pixel;
         if (DrawArea)    cnt_da++;
         if (hSync)       cnt_hs++;
         if (!vSync)      cnt_vs_low++;
         if (frame_start) cnt_fs++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 2'd0; solid_rgb = 24'h0;
      cnt_da = 0; cnt_hs = 0; cnt_vs_low = 0; cnt_fs = 0;
      repeat (3) tick();
      check("rst_hsync", 32'(hSync), 32'd0);
      check("rst_vsync", 32'(vSync), 32'd1);
      check("rst_fcnt", 32'(frame_cnt), 32'd0);

      // Two frames of gray bands
      rst = 1'b0;
      run_range(0, FRAME - 1);
      for (int y = 0; y < P_H; y++) check("gray_row", 32'(pix[y * LINE]), 32'(GRAY[y]));
      run_range(0, FRAME - 1);
      check("da_count", cnt_da, 64);
      check("hs_count", cnt_hs, 24);
      check("vs_low_count", cnt_vs_low, 24);
      check("fs_count", cnt_fs, 2);
      check("fcnt_two", 32'(frame_cnt), 32'd2);

      // Colour bars take effect one frame after the request
      mode = 2'd1;
      run_range(0, FRAME - 1);
      run_range(0, FRAME - 1);
      for (int i = 0; i < 8; i++) check("bars", 32'(pix[i]), 32'(BAR_RGB[i]));

      mode = 2'd2;
      run_range(0, FRAME - 1);
      run_range(0, FRAME - 1);
      for (int i = 0; i < 8; i++) begin
         check("chk_row0", 32'(pix[i]), 32'(CHK0[i]));
         check("chk_row2", 32'(pix[2 * LINE + i]), 32'(CHK2[i]));
      end

      // Mid-frame switch to solid must wait for the next frame
      mode = 2'd0;
      run_range(0, FRAME - 1);
      run_range(0, LINE);
      mode = 2'd3; solid_rgb = 24'h123456;
      run_range(LINE + 1, FRAME - 1);
      check("stay_gray1", 32'(pix[LINE]), 32'haaaaaa);
      check("stay_gray2", 32'(pix[2 * LINE]), 32'h555555);
      run_range(0, FRAME - 1);
      check("solid_first", 32'(pix[0]), 32'h123456);
      check("solid_last", 32'(pix[3 * LINE + 7]), 32'h123456);
      check("solid_hblank", 32'(pix[8]), 32'h0);
      check("solid_vblank", 32'(pix[4 * LINE]), 32'h0);

      // Stall mid-line
      run_range(0, 3);
      en = 1'b0;
      repeat (5) begin
         tick();
         check("stall_x", 32'(xOut), 32'd3);
      end
      en = 1'b1;
      tick();
      check("resume_x", 32'(xOut), 32'd4);
      run_range(5, FRAME - 1);

      // Reset mid-frame
      run_range(0, 2 * LINE + 6);
      rst = 1'b1;
      tick();
      check("mid_rst_hsync", 32'(hSync), 32'd0);
      check("mid_rst_vsync", 32'(vSync), 32'd1);
      check("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
      rst = 1'b0;
      tick();
      check("restart_x", 32'(xOut), 32'd0);
      check("restart_y", 32'(yOut), 32'd0);
      check("restart_fs", 32'(frame_start), 32'd1);
      run_range(1, FRAME - 1);
      check("fcnt_after_rst", 32'(frame_cnt), 32'd1);

      // Random en/mode/solid/reset traffic
      for (int i = 0; i < 2500; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 39) == 0) solid_rgb = 24'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
